// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the fetch-side branch predictor.
//   - Default index widths for the pattern history table and the BTB.
//   - 2-bit saturating counter encodings.
//   - BTB entry layout.
//   - sat_update(): next value of a 2-bit counter after a resolved branch.
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int PHT_IDX_W_DEF = 8;
    localparam int BTB_IDX_W_DEF = 6;

    // The tag field is sized for the narrowest possible index (30 bits of
    // word address). Narrower real tags are zero-extended, so the unused
    // upper bits are constant zero and drop out in synthesis.
    localparam int BTB_TAG_MAX_W = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [31:0]              target;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// -----------------------------------------------------------------------------
// bp_btb
// Direct-mapped branch target buffer with one combinational lookup port and
// one registered write port.
//   clk, rst      clock, asynchronous active-high reset (clears every entry)
//   i_rd_pc       fetch PC to look up
//   o_hit         entry valid and tag equal to i_rd_pc's tag
//   o_target      stored target on a hit, zero otherwise
//   i_wr_en       write the entry selected by i_wr_pc on this clock edge
//   i_wr_pc       PC of the resolved taken branch
//   i_wr_target   resolved target to store
// A read and write of the same entry in one cycle returns the old contents.
// -----------------------------------------------------------------------------
module bp_btb
    import bp_pkg::*;
#(
    parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_rd_pc,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_pc,
    input  logic [31:0] i_wr_target
);

    localparam int ENTRIES = 2 ** BTB_IDX_W;

    btb_entry_t r_btb [ENTRIES];

    logic [BTB_IDX_W-1:0]     w_rd_idx;
    logic [BTB_TAG_MAX_W-1:0] w_rd_tag;
    logic [BTB_IDX_W-1:0]     w_wr_idx;
    logic [BTB_TAG_MAX_W-1:0] w_wr_tag;
    btb_entry_t               w_rd_entry;
    logic                     w_unused_pc_lo;

    // Instructions are word aligned; the byte offset never enters the BTB.
    assign w_unused_pc_lo = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

    assign w_rd_idx = i_rd_pc[BTB_IDX_W+1:2];
    assign w_rd_tag = {{BTB_IDX_W{1'b0}}, i_rd_pc[31:BTB_IDX_W+2]};
    assign w_wr_idx = i_wr_pc[BTB_IDX_W+1:2];
    assign w_wr_tag = {{BTB_IDX_W{1'b0}}, i_wr_pc[31:BTB_IDX_W+2]};

    assign w_rd_entry = r_btb[w_rd_idx];
    assign o_hit      = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
    assign o_target   = o_hit ? w_rd_entry.target : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '0;
            end
        end else if (i_wr_en) begin
            // A taken resolution always claims the slot, evicting any alias.
            r_btb[w_wr_idx] <= '{valid: 1'b1, tag: w_wr_tag, target: i_wr_target};
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Gshare direction predictor (2-bit counters indexed by PC xor global
// history) plus a direct-mapped BTB, with two performance counters.
//   clk, rst          clock, asynchronous active-high reset
//   F_PC              fetch PC looked up combinationally
//   F_pred_taken      predicted direction (counter MSB)
//   F_pht_idx         counter index used; travels with the instruction to EX
//   F_btb_hit         BTB hit for F_PC
//   F_btb_target      BTB target, zero on a miss
//   F_pred_next_pc    predicted next fetch PC
//   ex_update_en      EX resolved a control-transfer instruction this cycle
//   ex_pc, ex_pht_idx, ex_actual_taken, ex_actual_target   resolution bundle
//   redirect_valid    EX redirected fetch after a mispredict this cycle
//   perf_update_cnt   saturating count of accepted updates
//   perf_mispred_cnt  saturating count of redirects
//
// Bundle semantics: the resolution bundle is valid-only. Its fields are
// meaningful in a cycle where ex_update_en is high and are consumed on that
// clock edge; there is no ready, the predictor accepts every update outside
// reset. redirect_valid is a single-cycle event with no payload.
//
// History is trained only at resolution, so a lookup sees the history of all
// branches resolved so far, never of in-flight ones. Lookups see state as of
// the last edge: an update in the same cycle becomes visible one cycle later.
// The state flops release from reset on the clock edge, so an update present
// on the first edge after rst falls is accepted.
// -----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         PHT_IDX_W = PHT_IDX_W_DEF,
    parameter int         BTB_IDX_W = BTB_IDX_W_DEF,
    parameter logic [1:0] PHT_INIT  = WNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          F_PC,
    output logic                 F_pred_taken,
    output logic [PHT_IDX_W-1:0] F_pht_idx,
    output logic                 F_btb_hit,
    output logic [31:0]          F_btb_target,
    output logic [31:0]          F_pred_next_pc,
    input  logic                 ex_update_en,
    input  logic [31:0]          ex_pc,
    input  logic [PHT_IDX_W-1:0] ex_pht_idx,
    input  logic                 ex_actual_taken,
    input  logic [31:0]          ex_actual_target,
    input  logic                 redirect_valid,
    output logic [31:0]          perf_update_cnt,
    output logic [31:0]          perf_mispred_cnt
);

    localparam int PHT_ENTRIES = 2 ** PHT_IDX_W;

    logic [1:0]           r_pht [PHT_ENTRIES];
    logic [PHT_IDX_W-1:0] r_ghr;
    logic [31:0]          r_perf_upd;
    logic [31:0]          r_perf_mis;

    logic [PHT_IDX_W-1:0] w_pht_idx;
    logic [1:0]           w_pht_ctr;
    logic                 w_btb_hit;
    logic [31:0]          w_btb_target;
    logic                 w_btb_wr;

    // ---------------- lookup ----------------
    assign w_pht_idx = F_PC[PHT_IDX_W+1:2] ^ r_ghr;
    assign w_pht_ctr = r_pht[w_pht_idx];

    assign w_btb_wr = ex_update_en && ex_actual_taken;

    bp_btb #(
        .BTB_IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_rd_pc     (F_PC),
        .o_hit       (w_btb_hit),
        .o_target    (w_btb_target),
        .i_wr_en     (w_btb_wr),
        .i_wr_pc     (ex_pc),
        .i_wr_target (ex_actual_target)
    );

    // Reset forces a not-taken, no-hit prediction regardless of table state.
    assign F_pht_idx      = w_pht_idx;
    assign F_pred_taken   = !rst && w_pht_ctr[1];
    assign F_btb_hit      = !rst && w_btb_hit;
    assign F_btb_target   = F_btb_hit ? w_btb_target : 32'd0;
    assign F_pred_next_pc = (F_pred_taken && F_btb_hit) ? F_btb_target : (F_PC + 32'd4);

    // ---------------- training ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                r_pht[i] <= PHT_INIT;
            end
            r_ghr <= '0;
        end else if (ex_update_en) begin
            r_pht[ex_pht_idx] <= sat_update(r_pht[ex_pht_idx], ex_actual_taken);
            r_ghr             <= {r_ghr[PHT_IDX_W-2:0], ex_actual_taken};
        end
    end

    // ---------------- performance counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_upd <= '0;
            r_perf_mis <= '0;
        end else begin
            if (ex_update_en && (r_perf_upd != 32'hFFFF_FFFF)) r_perf_upd <= r_perf_upd + 32'd1;
            if (redirect_valid && (r_perf_mis != 32'hFFFF_FFFF)) r_perf_mis <= r_perf_mis + 32'd1;
        end
    end

    assign perf_update_cnt  = r_perf_upd;
    assign perf_mispred_cnt = r_perf_mis;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor. Inputs change 1 ns after a rising edge
// and outputs are sampled there too, well away from the next active edge.
// Expected values are worked out by hand from the gshare/BTB behaviour; the
// running global history is noted beside each scenario.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic [31:0]   F_PC;
    logic          F_pred_taken;
    logic [PW-1:0] F_pht_idx;
    logic          F_btb_hit;
    logic [31:0]   F_btb_target;
    logic [31:0]   F_pred_next_pc;
    logic          ex_update_en;
    logic [31:0]   ex_pc;
    logic [PW-1:0] ex_pht_idx;
    logic          ex_actual_taken;
    logic [31:0]   ex_actual_target;
    logic          redirect_valid;
    logic [31:0]   perf_update_cnt;
    logic [31:0]   perf_mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .F_PC             (F_PC),
        .F_pred_taken     (F_pred_taken),
        .F_pht_idx        (F_pht_idx),
        .F_btb_hit        (F_btb_hit),
        .F_btb_target     (F_btb_target),
        .F_pred_next_pc   (F_pred_next_pc),
        .ex_update_en     (ex_update_en),
        .ex_pc            (ex_pc),
        .ex_pht_idx       (ex_pht_idx),
        .ex_actual_taken  (ex_actual_taken),
        .ex_actual_target (ex_actual_target),
        .redirect_valid   (redirect_valid),
        .perf_update_cnt  (perf_update_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_update_en     = 1'b0;
        ex_pc            = 32'd0;
        ex_pht_idx       = '0;
        ex_actual_taken  = 1'b0;
        ex_actual_target = 32'd0;
        redirect_valid   = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [PW-1:0] idx,
                             input logic taken, input logic [31:0] tgt);
        ex_update_en     = 1'b1;
        ex_pc            = pc;
        ex_pht_idx       = idx;
        ex_actual_taken  = taken;
        ex_actual_target = tgt;
        step();
        drive_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst  = 1'b1;
        F_PC = 32'h100;
        drive_idle();
        #3;
        if (F_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got=%0b exp=0", F_pred_taken); end
        checks++;
        if (F_btb_hit !== 1'b0) begin errors++; $display("FAIL rst_btb_hit got=%0b exp=0", F_btb_hit); end
        checks++;
        if (F_pred_next_pc !== 32'h104) begin errors++; $display("FAIL rst_next_pc got=%h exp=00000104", F_pred_next_pc); end
        checks++;
        if (perf_update_cnt !== 32'd0 || perf_mispred_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_update_cnt, perf_mispred_cnt);
        end
        checks++;
        step();
        step();
        rst = 1'b0;
        #1;
        // GHR = 0 -> idx = 0x100[9:2] = 0x40
        if (F_pht_idx !== 8'h40) begin errors++; $display("FAIL idle_pht_idx got=%h exp=40", F_pht_idx); end
        checks++;
        if (F_btb_target !== 32'd0) begin errors++; $display("FAIL idle_btb_target got=%h exp=0", F_btb_target); end
        checks++;
    endtask

    task automatic test_train();
        do_update(32'h100, 8'h40, 1'b1, 32'h200);
        do_update(32'h100, 8'h40, 1'b1, 32'h200);
        // GHR = 0x03, PHT[0x40] = 11
        F_PC = 32'h100;
        #1;
        if (F_pht_idx !== 8'h43) begin errors++; $display("FAIL train_idx got=%h exp=43", F_pht_idx); end
        checks++;
        if (F_pred_taken !== 1'b0) begin errors++; $display("FAIL train_pred_43 got=%0b exp=0", F_pred_taken); end
        checks++;
        if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h200) begin
            errors++; $display("FAIL train_btb got=%0b/%h exp=1/00000200", F_btb_hit, F_btb_target);
        end
        checks++;
        if (F_pred_next_pc !== 32'h104) begin errors++; $display("FAIL train_next_pc got=%h exp=00000104", F_pred_next_pc); end
        checks++;
        if (perf_update_cnt !== 32'd2) begin errors++; $display("FAIL train_perf got=%0d exp=2", perf_update_cnt); end
        checks++;
        // 0x10C -> 0x43 ^ 0x03 = 0x40 (counter 11); BTB slot 3 empty
        F_PC = 32'h10C;
        #1;
        if (F_pht_idx !== 8'h40 || F_pred_taken !== 1'b1) begin
            errors++; $display("FAIL train_pred_40 got=%h/%0b exp=40/1", F_pht_idx, F_pred_taken);
        end
        checks++;
        if (F_btb_hit !== 1'b0 || F_pred_next_pc !== 32'h110) begin
            errors++; $display("FAIL train_miss got=%0b/%h exp=0/00000110", F_btb_hit, F_pred_next_pc);
        end
        checks++;
    endtask

    task automatic test_saturation();
        // Three not-taken on idx 0x10: 01 -> 00 -> 00 -> 00. GHR 03->06->0C->18
        for (int i = 0; i < 3; i++) do_update(32'h100, 8'h10, 1'b0, 32'hDEAD_0000);
        F_PC = 32'h100;
        #1;
        if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h200) begin
            errors++; $display("FAIL sat_btb_kept got=%0b/%h exp=1/00000200", F_btb_hit, F_btb_target);
        end
        checks++;
        // One taken -> 01. GHR = 0x31. BTB gets 0x180 -> 0x400.
        do_update(32'h180, 8'h10, 1'b1, 32'h400);
        F_PC = 32'h84;   // 0x21 ^ 0x31 = 0x10
        #1;
        if (F_pht_idx !== 8'h10 || F_pred_taken !== 1'b0) begin
            errors++; $display("FAIL sat_floor got=%h/%0b exp=10/0", F_pht_idx, F_pred_taken);
        end
        checks++;
        // Another taken -> 10. GHR = 0x63.
        do_update(32'h180, 8'h10, 1'b1, 32'h400);
        F_PC = 32'h1CC;  // 0x73 ^ 0x63 = 0x10
        #1;
        if (F_pht_idx !== 8'h10 || F_pred_taken !== 1'b1) begin
            errors++; $display("FAIL sat_climb got=%h/%0b exp=10/1", F_pht_idx, F_pred_taken);
        end
        checks++;
        F_PC = 32'h180;
        #1;
        if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h400) begin
            errors++; $display("FAIL sat_btb_new got=%0b/%h exp=1/00000400", F_btb_hit, F_btb_target);
        end
        checks++;
    endtask

    task automatic test_alias();
        // 0x100 and 0x200 share BTB slot 0 with tags 1 and 2. GHR 63->C7->8F
        do_update(32'h100, 8'h05, 1'b1, 32'h200);
        do_update(32'h200, 8'h05, 1'b1, 32'h300);
        F_PC = 32'h100;
        #1;
        if (F_btb_hit !== 1'b0 || F_btb_target !== 32'd0) begin
            errors++; $display("FAIL alias_evicted got=%0b/%h exp=0/0", F_btb_hit, F_btb_target);
        end
        checks++;
        F_PC = 32'h200;  // idx 0x80 ^ 0x8F = 0x0F, counter 01
        #1;
        if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h300) begin
            errors++; $display("FAIL alias_hit got=%0b/%h exp=1/00000300", F_btb_hit, F_btb_target);
        end
        checks++;
        if (F_pht_idx !== 8'h0F || F_pred_next_pc !== 32'h204) begin
            errors++; $display("FAIL alias_next got=%h/%h exp=0f/00000204", F_pht_idx, F_pred_next_pc);
        end
        checks++;
    endtask

    task automatic test_same_cycle();
        // GHR = 0x8F; F_PC 0x368 -> 0xDA ^ 0x8F = 0x55 (counter 01)
        F_PC             = 32'h368;
        ex_update_en     = 1'b1;
        ex_pc            = 32'h368;
        ex_pht_idx       = 8'h55;
        ex_actual_taken  = 1'b1;
        ex_actual_target = 32'h500;
        #1;
        if (F_pht_idx !== 8'h55 || F_pred_taken !== 1'b0) begin
            errors++; $display("FAIL same_cyc_pred got=%h/%0b exp=55/0", F_pht_idx, F_pred_taken);
        end
        checks++;
        if (F_btb_hit !== 1'b0) begin errors++; $display("FAIL same_cyc_btb got=%0b exp=0", F_btb_hit); end
        checks++;
        step();
        drive_idle();
        // GHR = 0x1F; 0x128 -> 0x4A ^ 0x1F = 0x55 (counter 10)
        F_PC = 32'h128;
        #1;
        if (F_pht_idx !== 8'h55 || F_pred_taken !== 1'b1) begin
            errors++; $display("FAIL next_cyc_pred got=%h/%0b exp=55/1", F_pht_idx, F_pred_taken);
        end
        checks++;
        F_PC = 32'h368;
        #1;
        if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h500) begin
            errors++; $display("FAIL next_cyc_btb got=%0b/%h exp=1/00000500", F_btb_hit, F_btb_target);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        // Updates so far: 2 + 3 + 2 + 2 + 1 = 10
        redirect_valid = 1'b1;
        step();
        step();
        ex_update_en    = 1'b1;
        ex_pht_idx      = 8'h77;
        ex_actual_taken = 1'b0;
        step();
        drive_idle();
        if (perf_mispred_cnt !== 32'd3) begin errors++; $display("FAIL perf_mispred got=%0d exp=3", perf_mispred_cnt); end
        checks++;
        if (perf_update_cnt !== 32'd11) begin errors++; $display("FAIL perf_update got=%0d exp=11", perf_update_cnt); end
        checks++;
    endtask

    task automatic test_reset_midstream();
        F_PC             = 32'h100;
        ex_update_en     = 1'b1;
        ex_pc            = 32'h100;
        ex_pht_idx       = 8'h40;
        ex_actual_taken  = 1'b1;
        ex_actual_target = 32'h999;
        redirect_valid   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        if (perf_update_cnt !== 32'd0 || perf_mispred_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_rst_perf got=%0d/%0d exp=0/0", perf_update_cnt, perf_mispred_cnt);
        end
        checks++;
        if (F_btb_hit !== 1'b0 || F_pred_next_pc !== 32'h104) begin
            errors++; $display("FAIL mid_rst_out got=%0b/%h exp=0/00000104", F_btb_hit, F_pred_next_pc);
        end
        checks++;
        step();
        step();
        redirect_valid  = 1'b0;
        ex_actual_taken = 1'b0;
        rst             = 1'b0;
        #1;
        // PHT[0x40] was 11 before reset, GHR is 0 again -> 01 now
        if (F_pht_idx !== 8'h40 || F_pred_taken !== 1'b0 || F_btb_hit !== 1'b0) begin
            errors++; $display("FAIL post_rst_lookup got=%h/%0b/%0b exp=40/0/0", F_pht_idx, F_pred_taken, F_btb_hit);
        end
        checks++;
        step();
        drive_idle();
        if (perf_update_cnt !== 32'd1 || perf_mispred_cnt !== 32'd0) begin
            errors++; $display("FAIL post_rst_perf got=%0d/%0d exp=1/0", perf_update_cnt, perf_mispred_cnt);
        end
        checks++;
        F_PC = 32'h100;
        #1;
        if (F_btb_hit !== 1'b0) begin errors++; $display("FAIL post_rst_btb got=%0b exp=0", F_btb_hit); end
        checks++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_train();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
